branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences the branch comparator in the ID stage of the 5-stage pipeline.
//  Accepts a decoded branch, stalls IF/ID until both operands are hazard-free,
//  latches them into the comparator, then redirects the PC and flushes IF/ID.
//  Sits between decode, the hazard unit, the comparator and the PC mux.
// PARAMETERS
//  DW          16  datapath / register width
//  FLUSH_CYC    1  cycles flush held high after a taken branch (1..3)
//  WAIT_MAX    15  max operand-wait cycles before timeout (counter = 4 bits)
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous reset, active low
//  br_valid       in   1   ID holds a branch this cycle
//  br_op          in   2   branch opcode; 2'b00 = not a branch
//  br_target      in   DW  branch target address
//  reg_in         in   DW  first operand from register file
//  reg15_in       in   DW  second operand (R15) from register file
//  opnd_ready     in   1   hazard unit: both operands valid this cycle
//  kill           in   1   squash the in-flight branch (upstream flush)
//  cmpr_op        out  2   opcode driven to comparator
//  cmpr_a         out  DW  latched operand A to comparator
//  cmpr_b         out  DW  latched operand B to comparator
//  cmpr_jmp_true  in   1   comparator decision (combinational on cmpr_*)
//  stall          out  1   hold PC and IF/ID
//  flush          out  1   zero IF/ID
//  pc_sel         out  1   1 = PC mux selects pc_target (one-cycle pulse)
//  pc_target      out  DW  latched target
//  timeout        out  1   sticky: operand wait exceeded WAIT_MAX
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; wait counter 0; stats counters 0.
//  All outputs are registered or decoded from the registered state only.
//  IDLE: br_valid & br_op!=00 -> latch op/target; if opnd_ready latch
//    reg_in/reg15_in into cmpr_a/b and go RESOLVE, else go WAIT. br_op==00
//    or !br_valid: stay, no stall.
//  WAIT: stall=1; count++; opnd_ready -> latch operands, go RESOLVE;
//    count==WAIT_MAX and !opnd_ready -> set timeout, go IDLE, stall drops.
//  RESOLVE: stall=1; sample cmpr_jmp_true at clock edge. Taken -> REDIRECT;
//    not taken -> IDLE.
//  REDIRECT: pc_sel=1 for first cycle only; flush=1 for FLUSH_CYC cycles;
//    stall=0; then IDLE. New br_valid ignored until IDLE.
//  Latency (ready operands): accept c0, RESOLVE c1, pc_sel/flush c2.
//  kill in WAIT or RESOLVE -> IDLE next cycle, no pc_sel/flush; kill in
//    REDIRECT ignored. kill and opnd_ready same cycle: kill wins.
//  br_valid outside IDLE ignored (upstream is held by stall).
//  cmpr_a/b/op hold value outside RESOLVE; wait counter clears on exit WAIT.
//  timeout clears only on reset. rst_n low mid-sequence: immediate IDLE.
// CONFIGURATION
//  BRANCH_STATS_EN defined: adds outputs taken_cnt[15:0], nt_cnt[15:0],
//    stall_cnt[15:0]; incremented on RESOLVE exit taken / not taken and
//    each stall cycle; saturate at 16'hFFFF, never wrap.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  branch_ctrl_pkg: state encoding (IDLE,WAIT,RESOLVE,REDIRECT), br_op
//    codes (BR_NONE=2'b00), FLUSH_CYC/WAIT_MAX limits.
//  Sub-module: sat_cnt16 (saturating counter), used only under
//    BRANCH_STATS_EN. Comparator itself stays external.
// TESTING
//  op=01,a=10,b=15,ready,jmp=1 -> RESOLVE c1, pc_sel=1 c2, pc_target=br_target.
//  op=10,ready,jmp=0 -> stall c1 only, no flush, back to IDLE c2.
//  ready low 3 cycles then high -> stall 4 cycles, cmpr_a = reg_in at ready.
//  ready never high -> timeout=1 after 15 wait cycles, stall drops, IDLE.
//  kill during WAIT -> IDLE next cycle, pc_sel/flush never asserted.
//  op=00 br_valid=1 -> no stall; rst_n low in RESOLVE -> all outputs 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared state encoding, branch opcodes and timing limits for the ID-stage branch resolver.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        RESOLVE  = 2'd2,
        REDIRECT = 2'd3
    } brState_t;

    localparam logic [1:0] BR_NONE = 2'b00;

    localparam int FLUSH_CYC_DEF = 1;
    localparam int WAIT_MAX_DEF  = 15;
    localparam int WAIT_CW       = 4;
    localparam int FLUSH_CW      = 2;

endpackage

// File: rtl/branch_resolve_ctrl_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 16'h0000;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'd1;
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch sequencer: waits for operands, feeds the comparator, redirects PC.
// Optional BRANCH_STATS_EN adds saturating taken / not-taken / stall-cycle counters.
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int DW        = 16,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF,
    parameter int WAIT_MAX  = WAIT_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          br_valid,
    input  logic [1:0]    br_op,
    input  logic [DW-1:0] br_target,
    input  logic [DW-1:0] reg_in,
    input  logic [DW-1:0] reg15_in,
    input  logic          opnd_ready,
    input  logic          kill,
    output logic [1:0]    cmpr_op,
    output logic [DW-1:0] cmpr_a,
    output logic [DW-1:0] cmpr_b,
    input  logic          cmpr_jmp_true,
    output logic          stall,
    output logic          flush,
    output logic          pc_sel,
    output logic [DW-1:0] pc_target,
    output logic          timeout
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]   taken_cnt,
    output logic [15:0]   nt_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    brState_t              state, stateNext;
    logic [WAIT_CW-1:0]    waitCnt, waitCntNext, waitInc;
    logic [FLUSH_CW-1:0]   flushCnt, flushCntNext;
    logic                  accept, latchOpnd, timeoutSet;

    assign waitInc = waitCnt + 1'b1;

    // Kill has priority over operand arrival and over the timeout check.
    always_comb begin
        stateNext    = state;
        waitCntNext  = waitCnt;
        flushCntNext = flushCnt;
        accept       = 1'b0;
        latchOpnd    = 1'b0;
        timeoutSet   = 1'b0;
        case (state)
            IDLE: begin
                if (br_valid && br_op != BR_NONE) begin
                    accept = 1'b1;
                    if (opnd_ready) begin
                        latchOpnd = 1'b1;
                        stateNext = RESOLVE;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (kill) begin
                    stateNext   = IDLE;
                    waitCntNext = '0;
                end else if (opnd_ready) begin
                    latchOpnd   = 1'b1;
                    stateNext   = RESOLVE;
                    waitCntNext = '0;
                end else if (waitInc == WAIT_CW'(WAIT_MAX)) begin
                    timeoutSet  = 1'b1;
                    stateNext   = IDLE;
                    waitCntNext = '0;
                end else begin
                    waitCntNext = waitInc;
                end
            end
            RESOLVE: begin
                if (kill)
                    stateNext = IDLE;
                else if (cmpr_jmp_true)
                    stateNext = REDIRECT;
                else
                    stateNext = IDLE;
            end
            REDIRECT: begin
                if (flushCnt == FLUSH_CW'(FLUSH_CYC - 1)) begin
                    stateNext    = IDLE;
                    flushCntNext = '0;
                end else begin
                    flushCntNext = flushCnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            waitCnt  <= '0;
            flushCnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= stateNext;
            waitCnt  <= waitCntNext;
            flushCnt <= flushCntNext;
            if (timeoutSet)
                timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmpr_op   <= BR_NONE;
            pc_target <= '0;
            cmpr_a    <= '0;
            cmpr_b    <= '0;
        end else begin
            if (accept) begin
                cmpr_op   <= br_op;
                pc_target <= br_target;
            end
            if (latchOpnd) begin
                cmpr_a <= reg_in;
                cmpr_b <= reg15_in;
            end
        end
    end

    assign stall  = (state == WAIT) || (state == RESOLVE);
    assign flush  = (state == REDIRECT);
    assign pc_sel = (state == REDIRECT) && (flushCnt == '0);

`ifdef BRANCH_STATS_EN
    logic takenInc, ntInc;

    assign takenInc = (state == RESOLVE) && !kill && cmpr_jmp_true;
    assign ntInc    = (state == RESOLVE) && !kill && !cmpr_jmp_true;

    sat_cnt16 uTakenCnt (.clk(clk), .rst_n(rst_n), .inc(takenInc), .count(taken_cnt));
    sat_cnt16 uNtCnt    (.clk(clk), .rst_n(rst_n), .inc(ntInc),    .count(nt_cnt));
    sat_cnt16 uStallCnt (.clk(clk), .rst_n(rst_n), .inc(stall),    .count(stall_cnt));
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus randomized traffic vs a phase model.
module tb_branch_resolve_ctrl;

    localparam int DW        = 16;
    localparam int FLUSH_CYC = 1;
    localparam int WAIT_MAX  = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          br_valid;
    logic [1:0]    br_op;
    logic [DW-1:0] br_target, reg_in, reg15_in;
    logic          opnd_ready, kill, cmpr_jmp_true;
    logic [1:0]    cmpr_op;
    logic [DW-1:0] cmpr_a, cmpr_b, pc_target;
    logic          stall, flush, pc_sel, timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.DW(DW), .FLUSH_CYC(FLUSH_CYC), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_op(br_op),
        .br_target(br_target), .reg_in(reg_in), .reg15_in(reg15_in),
        .opnd_ready(opnd_ready), .kill(kill), .cmpr_op(cmpr_op),
        .cmpr_a(cmpr_a), .cmpr_b(cmpr_b), .cmpr_jmp_true(cmpr_jmp_true),
        .stall(stall), .flush(flush), .pc_sel(pc_sel), .pc_target(pc_target),
        .timeout(timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 waiting for operands, 2 comparing, 3 redirecting.
    int            mPhase, mWaited, mFlushLeft;
    logic [1:0]    eOp;
    logic [DW-1:0] eA, eB, eTgt;
    logic          eTimeout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase = 0; mWaited = 0; mFlushLeft = 0;
            eOp = 0; eA = 0; eB = 0; eTgt = 0; eTimeout = 0;
        end else begin
            case (mPhase)
                0: if (br_valid && br_op != 2'b00) begin
                    eOp = br_op; eTgt = br_target;
                    if (opnd_ready) begin eA = reg_in; eB = reg15_in; mPhase = 2; end
                    else begin mPhase = 1; mWaited = 0; end
                end
                1: begin
                    mWaited++;
                    if (kill) mPhase = 0;
                    else if (opnd_ready) begin eA = reg_in; eB = reg15_in; mPhase = 2; end
                    else if (mWaited == WAIT_MAX) begin eTimeout = 1; mPhase = 0; end
                end
                2: begin
                    if (kill) mPhase = 0;
                    else if (cmpr_jmp_true) begin mPhase = 3; mFlushLeft = FLUSH_CYC; end
                    else mPhase = 0;
                end
                default: begin
                    mFlushLeft--;
                    if (mFlushLeft == 0) mPhase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("stall",     32'(stall),     32'(mPhase == 1 || mPhase == 2));
        chk("flush",     32'(flush),     32'(mPhase == 3));
        chk("pc_sel",    32'(pc_sel),    32'(mPhase == 3 && mFlushLeft == FLUSH_CYC));
        chk("timeout",   32'(timeout),   32'(eTimeout));
        chk("cmpr_op",   32'(cmpr_op),   32'(eOp));
        chk("cmpr_a",    32'(cmpr_a),    32'(eA));
        chk("cmpr_b",    32'(cmpr_b),    32'(eB));
        chk("pc_target", 32'(pc_target), 32'(eTgt));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clearIn();
        br_valid = 0; br_op = 0; kill = 0; opnd_ready = 0; cmpr_jmp_true = 0;
    endtask

    initial begin
        int sc;
        int hits;
        int readyPct;
        rst_n = 0; br_target = 0; reg_in = 0; reg15_in = 0;
        clearIn();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_pc_sel", 32'(pc_sel), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_pc_target", 32'(pc_target), 0);

        // Taken branch with ready operands: RESOLVE c1, redirect c2.
        br_valid = 1; br_op = 2'b01; br_target = 16'h1234; reg_in = 16'd10; reg15_in = 16'd15;
        opnd_ready = 1;
        tick();
        chk("t1_c1_stall", 32'(stall), 1);
        chk("t1_c1_a", 32'(cmpr_a), 10);
        chk("t1_c1_b", 32'(cmpr_b), 15);
        chk("t1_c1_op", 32'(cmpr_op), 1);
        chk("t1_c1_pc_sel", 32'(pc_sel), 0);
        clearIn(); cmpr_jmp_true = 1;
        tick();
        chk("t1_c2_pc_sel", 32'(pc_sel), 1);
        chk("t1_c2_flush", 32'(flush), 1);
        chk("t1_c2_stall", 32'(stall), 0);
        chk("t1_c2_target", 32'(pc_target), 32'h1234);
        clearIn();
        tick();
        chk("t1_c3_pc_sel", 32'(pc_sel), 0);
        chk("t1_c3_flush", 32'(flush), 0);

        // Not-taken: one stall cycle, no flush.
        br_valid = 1; br_op = 2'b10; opnd_ready = 1;
        tick();
        chk("t2_c1_stall", 32'(stall), 1);
        clearIn();
        tick();
        chk("t2_c2_stall", 32'(stall), 0);
        chk("t2_c2_flush", 32'(flush), 0);
        chk("t2_c2_pc_sel", 32'(pc_sel), 0);

        // Operands late by three cycles: four stall cycles in total.
        br_valid = 1; br_op = 2'b11; reg_in = 16'hAAAA; reg15_in = 16'h5555;
        sc = 0;
        tick(); sc += int'(stall);
        br_valid = 0;
        tick(); sc += int'(stall);
        tick(); sc += int'(stall);
        opnd_ready = 1; reg_in = 16'h0BEE; reg15_in = 16'h0CAF;
        tick(); sc += int'(stall);
        chk("t3_a", 32'(cmpr_a), 32'h0BEE);
        chk("t3_b", 32'(cmpr_b), 32'h0CAF);
        clearIn();
        tick(); sc += int'(stall);
        chk("t3_stall_len", 32'(sc), 4);

        // Operands never ready: timeout after WAIT_MAX wait cycles.
        chk("t4_timeout_pre", 32'(timeout), 0);
        br_valid = 1; br_op = 2'b01;
        sc = 0;
        tick(); sc += int'(stall);
        clearIn();
        for (int i = 0; i < 19; i++) begin tick(); sc += int'(stall); end
        chk("t4_stall_len", 32'(sc), WAIT_MAX);
        chk("t4_timeout", 32'(timeout), 1);
        chk("t4_stall_after", 32'(stall), 0);

        // Kill in WAIT (with ready in the same cycle): squashed, no redirect.
        br_valid = 1; br_op = 2'b10;
        tick();
        clearIn();
        tick();
        kill = 1; opnd_ready = 1;
        tick();
        chk("t5_stall", 32'(stall), 0);
        clearIn(); cmpr_jmp_true = 1;
        hits = 0;
        for (int i = 0; i < 3; i++) begin tick(); hits += int'(pc_sel) + int'(flush) + int'(stall); end
        chk("t5_no_redirect", 32'(hits), 0);

        // br_op none: no stall.
        clearIn(); br_valid = 1; br_op = 2'b00; opnd_ready = 1;
        tick();
        chk("t6_stall_c1", 32'(stall), 0);
        tick();
        chk("t6_stall_c2", 32'(stall), 0);

        // Reset while in RESOLVE clears everything immediately.
        br_op = 2'b01; br_target = 16'hBEEF; reg_in = 16'h0011; reg15_in = 16'h0022;
        tick();
        chk("t7_in_resolve", 32'(stall), 1);
        clearIn();
        rst_n = 0;
        #1;
        chk("t7_stall", 32'(stall), 0);
        chk("t7_timeout", 32'(timeout), 0);
        chk("t7_pc_target", 32'(pc_target), 0);
        chk("t7_cmpr_a", 32'(cmpr_a), 0);
        chk("t7_cmpr_op", 32'(cmpr_op), 0);
        rst_n = 1;
        tick();

        // Randomized traffic, checked each cycle by the compare process.
        readyPct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0)
                readyPct = ((i / 250) % 3 == 0) ? 5 : (((i / 250) % 3 == 1) ? 50 : 90);
            br_valid      = 1'($urandom_range(0, 1));
            br_op         = 2'($urandom_range(0, 3));
            br_target     = 16'($urandom);
            reg_in        = 16'($urandom);
            reg15_in      = 16'($urandom);
            opnd_ready    = ($urandom_range(0, 99) < readyPct);
            kill          = ($urandom_range(0, 19) == 0);
            cmpr_jmp_true = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 0;
                #1 rst_n = 1;
            end
            tick();
        end

        clearIn();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
